// File: rtl/glip_uart_core.sv
// Runtime-configurable UART transceiver for GLIP: framing, parity, RX/TX FIFOs, RTS/CTS.
// The integrating design supplies any clock-domain crossing beyond the line synchronisers.

module glip_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module glip_uart_core #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int DIV_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = FIFO_DEPTH - 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic                 uart_cts_n,
  output logic                 uart_rts_n,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  input  logic                 err_clear
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic rx_s1, rx_s2, cts_s1, cts_s2;
  logic [DIV_WIDTH-1:0] div_eff;

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_pop, rx_push, rx_push_ok;
  logic [LW-1:0]        rx_level_next;

  tx_state_t            tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n, tx_line, tx_load;

  rx_state_t            rx_state, rx_state_n;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_par, rx_par_n, rx_par_bad;
  logic                 set_frame, set_parity, set_overrun;

  assign div_eff = (divisor < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divisor;

  // Line inputs idle high, so the synchronisers reset to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      rx_s1  <= uart_rx;
      rx_s2  <= rx_s1;
      cts_s1 <= uart_cts_n;
      cts_s2 <= cts_s1;
    end
  end

  glip_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
    .head(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  glip_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .head(rx_data), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready      = !tx_full || tx_pop;
  assign rx_valid      = !rx_empty;
  assign rx_pop        = rx_valid && rx_ready;
  assign rx_push_ok    = rx_push && (!rx_full || rx_pop);
  assign set_overrun   = rx_push && rx_full && !rx_pop;
  assign rx_level_next = rx_level + LW'(rx_push_ok) - LW'(rx_pop);
  assign rx_par_bad    = ((^rx_shift) ^ rx_par) != (PARITY == 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_WIDTH'(4);
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      uart_tx  <= tx_line;
    end
  end

  // The frame start check lives in both IDLE and the last stop cycle so back-to-back frames have no gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line    = 1'b1;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: tx_load = !tx_empty && !cts_s2;
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt == '0) begin
          tx_cnt_n   = tx_div - 1'b1;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt - 1'b1;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_cnt == '0) begin
          tx_cnt_n   = tx_div - 1'b1;
          tx_shift_n = tx_shift >> 1;
          if (tx_bit == 3'(DATA_BITS - 1)) begin
            tx_bit_n   = '0;
            tx_state_n = (PARITY != 0) ? TX_PARITY : TX_STOP;
          end else tx_bit_n = tx_bit + 1'b1;
        end else tx_cnt_n = tx_cnt - 1'b1;
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_cnt == '0) begin
          tx_cnt_n   = tx_div - 1'b1;
          tx_bit_n   = '0;
          tx_state_n = TX_STOP;
        end else tx_cnt_n = tx_cnt - 1'b1;
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (tx_bit == 3'(STOP_BITS - 1)) begin
            tx_state_n = TX_IDLE;
            tx_load    = !tx_empty && !cts_s2;
          end else begin
            tx_cnt_n = tx_div - 1'b1;
            tx_bit_n = tx_bit + 1'b1;
          end
        end else tx_cnt_n = tx_cnt - 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_par_n   = (PARITY == 1) ? ~^tx_head : ^tx_head;
      tx_div_n   = div_eff;
      tx_cnt_n   = div_eff - 1'b1;
      tx_bit_n   = '0;
      tx_state_n = TX_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_div      <= DIV_WIDTH'(4);
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_par      <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
      uart_rts_n  <= 1'b1;
    end else begin
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_div      <= rx_div_n;
      rx_bit      <= rx_bit_n;
      rx_shift    <= rx_shift_n;
      rx_par      <= rx_par_n;
      err_frame   <= set_frame   || (err_frame   && !err_clear);
      err_parity  <= set_parity  || (err_parity  && !err_clear);
      err_overrun <= set_overrun || (err_overrun && !err_clear);
      uart_rts_n  <= (rx_level_next >= LW'(RTS_THRESHOLD));
    end
  end

  // Only the first stop bit is checked; returning to IDLE right after it accepts 1-stop peers.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_div_n   = div_eff;
          rx_cnt_n   = (div_eff >> 1) - 1'b1;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) rx_state_n = RX_IDLE;
          else begin
            rx_cnt_n   = rx_div - 1'b1;
            rx_bit_n   = '0;
            rx_state_n = RX_DATA;
          end
        end else rx_cnt_n = rx_cnt - 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_n   = rx_div - 1'b1;
          rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == 3'(DATA_BITS - 1))
            rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
          else rx_bit_n = rx_bit + 1'b1;
        end else rx_cnt_n = rx_cnt - 1'b1;
      end
      RX_PARITY: begin
        if (rx_cnt == '0) begin
          rx_cnt_n   = rx_div - 1'b1;
          rx_par_n   = rx_s2;
          rx_state_n = RX_STOP;
        end else rx_cnt_n = rx_cnt - 1'b1;
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (!rx_s2) begin
            set_frame  = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end else begin
            rx_state_n = RX_IDLE;
            if ((PARITY != 0) && rx_par_bad) set_parity = 1'b1;
            else rx_push = 1'b1;
          end
        end else rx_cnt_n = rx_cnt - 1'b1;
      end
      RX_WAIT_HIGH: if (rx_s2) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_glip_uart_core.sv
// Directed bench for glip_uart_core: an 8N1 instance and a 7E2 instance, mostly in loopback,
// plus hand-driven serial frames for errors, overrun, flow control, glitches and async reset.

module tb_glip_uart_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] divisor;
  logic [7:0]  tx_data;
  logic        cts_n, err_clear, rx_drv, loop_a, loop_b, sel_b;

  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_uart_rx, a_uart_tx, a_rts_n;
  logic       a_err_frame, a_err_parity, a_err_overrun;
  logic [7:0] a_rx_data;
  logic [4:0] a_tx_level, a_rx_level;

  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_uart_rx, b_uart_tx, b_rts_n;
  logic       b_err_frame, b_err_parity, b_err_overrun;
  logic [6:0] b_rx_data;
  logic [4:0] b_tx_level, b_rx_level;

  assign a_uart_rx = loop_a ? a_uart_tx : rx_drv;
  assign b_uart_rx = loop_b ? b_uart_tx : rx_drv;

  glip_uart_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .tx_data(tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_level(a_tx_level), .rx_level(a_rx_level), .uart_rx(a_uart_rx), .uart_tx(a_uart_tx),
    .uart_cts_n(cts_n), .uart_rts_n(a_rts_n), .err_frame(a_err_frame), .err_parity(a_err_parity),
    .err_overrun(a_err_overrun), .err_clear(err_clear)
  );

  glip_uart_core #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .tx_data(tx_data[6:0]), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .tx_level(b_tx_level), .rx_level(b_rx_level), .uart_rx(b_uart_rx), .uart_tx(b_uart_tx),
    .uart_cts_n(cts_n), .uart_rts_n(b_rts_n), .err_frame(b_err_frame), .err_parity(b_err_parity),
    .err_overrun(b_err_overrun), .err_clear(err_clear)
  );

  logic       obs_tx, obs_rx_valid;
  logic [7:0] obs_data;
  logic [2:0] obs_err;
  always_comb begin
    obs_tx       = sel_b ? b_uart_tx : a_uart_tx;
    obs_rx_valid = sel_b ? b_rx_valid : a_rx_valid;
    obs_data     = sel_b ? {1'b0, b_rx_data} : a_rx_data;
    obs_err      = sel_b ? {b_err_frame, b_err_parity, b_err_overrun}
                         : {a_err_frame, a_err_parity, a_err_overrun};
  end

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic [15:0] div;
    int          per;
    int          nbits;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic popRx(input logic b);
    if (b) b_rx_ready = 1'b1;
    else a_rx_ready = 1'b1;
    tick(1);
    a_rx_ready = 1'b0;
    b_rx_ready = 1'b0;
  endtask

  task automatic driveSerial(input logic [10:0] frame, input int nbits, input int per);
    for (int k = 0; k < nbits; k++) begin
      rx_drv = frame[k];
      tick(per);
    end
    rx_drv = 1'b1;
  endtask

  // Sends one word, samples every serial bit mid-period, then checks the looped-back word.
  task automatic applyStimulus(input vec_t v);
    logic [10:0] got;
    got     = '0;
    sel_b   = v.sel;
    divisor = v.div;
    tx_data = v.data;
    if (v.sel) b_tx_valid = 1'b1;
    else a_tx_valid = 1'b1;
    tick(1);
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    tick(1);
    checkOutput("tx_idle_t+1", 32'(obs_tx), 32'd1);
    tick(1);
    checkOutput("tx_start_t+2", 32'(obs_tx), 32'd0);
    tick(v.per / 2);
    got[0] = obs_tx;
    for (int k = 1; k < v.nbits; k++) begin
      tick(v.per);
      got[k] = obs_tx;
    end
    checkOutput("tx_frame", 32'(got), 32'(v.frame));
    for (int i = 0; i < 4 * v.per && !obs_rx_valid; i++) tick(1);
    checkOutput("loop_rx_valid", 32'(obs_rx_valid), 32'd1);
    checkOutput("loop_rx_data", 32'(obs_data), 32'(v.data));
    checkOutput("loop_no_err", 32'(obs_err), 32'd0);
    popRx(v.sel);
    tick(v.per);
  endtask

  initial begin
    int lows;
    logic [10:0] f;

    vecs[0] = '{1'b0, 8'hA5, 16'd16, 16, 10, 11'h34A};
    vecs[1] = '{1'b0, 8'h00, 16'd4,  4,  10, 11'h200};
    vecs[2] = '{1'b0, 8'hFF, 16'd5,  5,  10, 11'h3FE};
    vecs[3] = '{1'b0, 8'h3C, 16'd2,  4,  10, 11'h278};
    vecs[4] = '{1'b0, 8'h81, 16'd7,  7,  10, 11'h302};
    vecs[5] = '{1'b1, 8'h35, 16'd8,  8,  11, 11'h66A};
    vecs[6] = '{1'b1, 8'h7F, 16'd8,  8,  11, 11'h7FE};
    vecs[7] = '{1'b1, 8'h00, 16'd6,  6,  11, 11'h600};

    rst_n = 1'b0; divisor = 16'd16; tx_data = '0; cts_n = 1'b0; err_clear = 1'b0;
    rx_drv = 1'b1; loop_a = 1'b1; loop_b = 1'b1; sel_b = 1'b0;
    a_tx_valid = 1'b0; a_rx_ready = 1'b0; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
    tick(3);
    checkOutput("rst_uart_tx", 32'(a_uart_tx), 32'd1);
    checkOutput("rst_rts_n", 32'(a_rts_n), 32'd1);
    checkOutput("rst_ready_valid", 32'({a_tx_ready, a_rx_valid}), 32'b10);
    checkOutput("rst_levels", 32'({a_tx_level, a_rx_level}), 32'd0);
    checkOutput("rst_errors", 32'({a_err_frame, a_err_parity, a_err_overrun}), 32'd0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("rts_after_release", 32'(a_rts_n), 32'd0);
    tick(3);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // 7E2 back-to-back: second start bit lands exactly 88 cycles after the first.
    sel_b = 1'b1; divisor = 16'd8; tx_data = 8'h35; b_tx_valid = 1'b1;
    tick(1);
    tx_data = 8'h00;
    tick(1);
    b_tx_valid = 1'b0;
    tick(1);
    checkOutput("b2b_first_start", 32'(b_uart_tx), 32'd0);
    tick(87);
    checkOutput("b2b_last_stop", 32'(b_uart_tx), 32'd1);
    tick(1);
    checkOutput("b2b_second_start", 32'(b_uart_tx), 32'd0);
    for (int i = 0; i < 300 && b_rx_level != 5'd2; i++) tick(1);
    checkOutput("b2b_rx_level", 32'(b_rx_level), 32'd2);
    checkOutput("b2b_word0", 32'(b_rx_data), 32'h35);
    popRx(1'b1);
    checkOutput("b2b_word1", 32'(b_rx_data), 32'h00);
    popRx(1'b1);
    checkOutput("b2b_no_err", 32'(obs_err), 32'd0);
    tick(100);

    // 7E2 frame carrying 0x01 with parity 0 instead of 1.
    loop_b = 1'b0;
    driveSerial(11'h602, 11, 8);
    tick(4);
    checkOutput("parity_err_set", 32'(obs_err), 32'b010);
    checkOutput("parity_no_word", 32'(b_rx_valid), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checkOutput("parity_err_clear", 32'(obs_err), 32'd0);
    loop_b = 1'b1;

    // 8N1 frame 0x55 with a low stop bit.
    sel_b = 1'b0; loop_a = 1'b0;
    driveSerial(11'h0AA, 10, 8);
    tick(4);
    checkOutput("frame_err_set", 32'(obs_err), 32'b100);
    checkOutput("frame_no_word", 32'(a_rx_valid), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checkOutput("frame_err_clear", 32'(obs_err), 32'd0);

    // Fill the RX FIFO: RTS deasserts at 12 words, the 17th word overruns.
    divisor = 16'd4;
    for (int i = 0; i < 17; i++) begin
      f = {1'b0, 1'b1, 8'(8'h40 + i), 1'b0};
      driveSerial(f, 10, 4);
      tick(4);
      checkOutput("rts_fill", 32'(a_rts_n), ((i + 1) >= 12) ? 32'd1 : 32'd0);
    end
    checkOutput("overrun_level", 32'(a_rx_level), 32'd16);
    checkOutput("overrun_err", 32'(obs_err), 32'b001);
    for (int i = 0; i < 16; i++) begin
      checkOutput("overrun_order", 32'(a_rx_data), 32'(8'h40 + i));
      popRx(1'b0);
    end
    checkOutput("drain_rts", 32'(a_rts_n), 32'd0);
    checkOutput("drain_level", 32'(a_rx_level), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;

    // CTS gating: nothing leaves while CTS is high; a frame in flight is allowed to finish.
    loop_a = 1'b1; cts_n = 1'b1;
    tick(3);
    a_tx_valid = 1'b1;
    tx_data = 8'h11; tick(1);
    tx_data = 8'h22; tick(1);
    tx_data = 8'h33; tick(1);
    a_tx_valid = 1'b0;
    checkOutput("cts_held_level", 32'(a_tx_level), 32'd3);
    lows = 0;
    repeat (30) begin tick(1); if (!a_uart_tx) lows++; end
    checkOutput("cts_held_idle", 32'(lows), 32'd0);
    cts_n = 1'b0;
    for (int i = 0; i < 20 && a_uart_tx; i++) tick(1);
    checkOutput("cts_release_start", 32'(a_uart_tx), 32'd0);
    tick(39);
    checkOutput("cts_f1_stop", 32'(a_uart_tx), 32'd1);
    tick(1);
    checkOutput("cts_f2_start", 32'(a_uart_tx), 32'd0);
    tick(10);
    cts_n = 1'b1;
    tick(31);
    lows = 0;
    repeat (45) begin tick(1); if (!a_uart_tx) lows++; end
    checkOutput("cts_f3_withheld", 32'(lows), 32'd0);
    checkOutput("cts_f3_queued", 32'(a_tx_level), 32'd1);
    cts_n = 1'b0;
    for (int i = 0; i < 200 && a_rx_level != 5'd3; i++) tick(1);
    checkOutput("cts_rx_level", 32'(a_rx_level), 32'd3);
    checkOutput("cts_word0", 32'(a_rx_data), 32'h11);
    popRx(1'b0);
    checkOutput("cts_word1", 32'(a_rx_data), 32'h22);
    popRx(1'b0);
    checkOutput("cts_word2", 32'(a_rx_data), 32'h33);
    popRx(1'b0);
    tick(20);

    // A short low pulse is rejected at the mid-start sample.
    loop_a = 1'b0; divisor = 16'd16;
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(40);
    checkOutput("glitch_no_word", 32'(a_rx_valid), 32'd0);
    checkOutput("glitch_no_err", 32'(obs_err), 32'd0);

    // Asynchronous reset while a zero data bit is on the line.
    tx_data = 8'h00; a_tx_valid = 1'b1;
    tick(2);
    a_tx_valid = 1'b0;
    tick(22);
    checkOutput("mid_tx_low", 32'(a_uart_tx), 32'd0);
    checkOutput("mid_tx_queued", 32'(a_tx_level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tx", 32'(a_uart_tx), 32'd1);
    checkOutput("async_rst_levels", 32'({a_tx_level, a_rx_level}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
